// File: rtl/instr_issue_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_issue_queue : compacting OoO issue queue, tag wakeup, oldest-ready select |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module instr_issue_queue #(
  parameter int DEPTH     = 16,
  parameter int PTAG_W    = 6,
  parameter int PAYLOAD_W = 96,
  parameter int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  input  logic [PTAG_W-1:0]    alloc_rs_phys,
  input  logic [PTAG_W-1:0]    alloc_rt_phys,
  input  logic [PTAG_W-1:0]    alloc_rw_phys,
  input  logic                 alloc_uses_rs,
  input  logic                 alloc_uses_rt,
  input  logic                 alloc_rs_rdy,
  input  logic                 alloc_rt_rdy,
  input  logic [PAYLOAD_W-1:0] alloc_payload,
  input  logic                 wb_valid,
  input  logic [PTAG_W-1:0]    wb_phys,
  output logic                 iss_valid,
  input  logic                 iss_ready,
  output logic [PTAG_W-1:0]    iss_rs_phys,
  output logic [PTAG_W-1:0]    iss_rt_phys,
  output logic [PTAG_W-1:0]    iss_rw_phys,
  output logic [PAYLOAD_W-1:0] iss_payload,
  output logic [CNT_W-1:0]     count
);

  localparam int IDX_W = $clog2(DEPTH);

  logic                 ent_valid  [DEPTH];
  logic [PTAG_W-1:0]    ent_rs     [DEPTH];
  logic [PTAG_W-1:0]    ent_rt     [DEPTH];
  logic [PTAG_W-1:0]    ent_rw     [DEPTH];
  logic                 ent_rs_rdy [DEPTH];
  logic                 ent_rt_rdy [DEPTH];
  logic [PAYLOAD_W-1:0] ent_pl     [DEPTH];
  logic [CNT_W-1:0]     occ;

  // Post-wakeup view of the entries; slot DEPTH is an always-empty sentinel
  // so the top entry can shift in "nothing" without a range special case.
  logic                 wk_valid  [DEPTH+1];
  logic [PTAG_W-1:0]    wk_rs     [DEPTH+1];
  logic [PTAG_W-1:0]    wk_rt     [DEPTH+1];
  logic [PTAG_W-1:0]    wk_rw     [DEPTH+1];
  logic                 wk_rs_rdy [DEPTH+1];
  logic                 wk_rt_rdy [DEPTH+1];
  logic [PAYLOAD_W-1:0] wk_pl     [DEPTH+1];

  logic                 nx_valid  [DEPTH];
  logic [PTAG_W-1:0]    nx_rs     [DEPTH];
  logic [PTAG_W-1:0]    nx_rt     [DEPTH];
  logic [PTAG_W-1:0]    nx_rw     [DEPTH];
  logic                 nx_rs_rdy [DEPTH];
  logic                 nx_rt_rdy [DEPTH];
  logic [PAYLOAD_W-1:0] nx_pl     [DEPTH];

  logic                 found;
  logic [IDX_W-1:0]     sel;
  logic [IDX_W:0]       src;
  logic                 issue_fire;
  logic                 alloc_fire;
  logic [CNT_W-1:0]     alloc_slot;
  logic                 new_rs_rdy;
  logic                 new_rt_rdy;

  assign count       = occ;
  assign alloc_ready = (occ < CNT_W'(DEPTH));

  // Slot order is age order, so the lowest ready index is the oldest ready.
  always_comb begin : select_oldest
    found = 1'b0;
    sel   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_valid[i] && ent_rs_rdy[i] && ent_rt_rdy[i]) begin
        found = 1'b1;
        sel   = IDX_W'(i);
      end
    end
  end

  assign iss_valid   = found & ~flush;
  assign iss_rs_phys = found ? ent_rs[sel] : '0;
  assign iss_rt_phys = found ? ent_rt[sel] : '0;
  assign iss_rw_phys = found ? ent_rw[sel] : '0;
  assign iss_payload = found ? ent_pl[sel] : '0;

  assign issue_fire = iss_valid & iss_ready;
  assign alloc_fire = alloc_valid & alloc_ready & ~flush;
  assign alloc_slot = occ - CNT_W'(issue_fire);
  assign new_rs_rdy = ~alloc_uses_rs | alloc_rs_rdy | (wb_valid & (wb_phys == alloc_rs_phys));
  assign new_rt_rdy = ~alloc_uses_rt | alloc_rt_rdy | (wb_valid & (wb_phys == alloc_rt_phys));

  always_comb begin : wakeup
    for (int i = 0; i < DEPTH; i++) begin
      wk_valid[i]  = ent_valid[i];
      wk_rs[i]     = ent_rs[i];
      wk_rt[i]     = ent_rt[i];
      wk_rw[i]     = ent_rw[i];
      wk_pl[i]     = ent_pl[i];
      wk_rs_rdy[i] = ent_rs_rdy[i] | (wb_valid & ent_valid[i] & (ent_rs[i] == wb_phys));
      wk_rt_rdy[i] = ent_rt_rdy[i] | (wb_valid & ent_valid[i] & (ent_rt[i] == wb_phys));
    end
    wk_valid[DEPTH]  = 1'b0;
    wk_rs[DEPTH]     = '0;
    wk_rt[DEPTH]     = '0;
    wk_rw[DEPTH]     = '0;
    wk_pl[DEPTH]     = '0;
    wk_rs_rdy[DEPTH] = 1'b0;
    wk_rt_rdy[DEPTH] = 1'b0;
  end

  // Entries at or above the issued slot pull from the slot above; the new
  // instruction lands on the first free slot after that compaction.
  always_comb begin : compact
    src = '0;
    for (int i = 0; i < DEPTH; i++) begin
      src          = (issue_fire && (i >= int'(sel))) ? (IDX_W+1)'(i + 1) : (IDX_W+1)'(i);
      nx_valid[i]  = wk_valid[src];
      nx_rs[i]     = wk_rs[src];
      nx_rt[i]     = wk_rt[src];
      nx_rw[i]     = wk_rw[src];
      nx_pl[i]     = wk_pl[src];
      nx_rs_rdy[i] = wk_rs_rdy[src];
      nx_rt_rdy[i] = wk_rt_rdy[src];
      if (alloc_fire && (alloc_slot == CNT_W'(i))) begin
        nx_valid[i]  = 1'b1;
        nx_rs[i]     = alloc_rs_phys;
        nx_rt[i]     = alloc_rt_phys;
        nx_rw[i]     = alloc_rw_phys;
        nx_pl[i]     = alloc_payload;
        nx_rs_rdy[i] = new_rs_rdy;
        nx_rt_rdy[i] = new_rt_rdy;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_valid[i]  <= 1'b0;
        ent_rs[i]     <= '0;
        ent_rt[i]     <= '0;
        ent_rw[i]     <= '0;
        ent_pl[i]     <= '0;
        ent_rs_rdy[i] <= 1'b0;
        ent_rt_rdy[i] <= 1'b0;
      end
    end else if (flush) begin
      occ <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_valid[i] <= 1'b0;
      end
    end else begin
      occ <= occ + CNT_W'(alloc_fire) - CNT_W'(issue_fire);
      for (int i = 0; i < DEPTH; i++) begin
        ent_valid[i]  <= nx_valid[i];
        ent_rs[i]     <= nx_rs[i];
        ent_rt[i]     <= nx_rt[i];
        ent_rw[i]     <= nx_rw[i];
        ent_pl[i]     <= nx_pl[i];
        ent_rs_rdy[i] <= nx_rs_rdy[i];
        ent_rt_rdy[i] <= nx_rt_rdy[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_issue_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_instr_issue_queue : scoreboard bench with an age-ordered list model     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_instr_issue_queue;

  localparam int DEPTH     = 16;
  localparam int PTAG_W    = 6;
  localparam int PAYLOAD_W = 96;
  localparam int CNT_W     = 5;

  logic                 clk = 1'b0;
  logic                 rst, flush, alloc_valid, alloc_ready;
  logic [PTAG_W-1:0]    alloc_rs_phys, alloc_rt_phys, alloc_rw_phys;
  logic                 alloc_uses_rs, alloc_uses_rt, alloc_rs_rdy, alloc_rt_rdy;
  logic [PAYLOAD_W-1:0] alloc_payload;
  logic                 wb_valid;
  logic [PTAG_W-1:0]    wb_phys;
  logic                 iss_valid, iss_ready;
  logic [PTAG_W-1:0]    iss_rs_phys, iss_rt_phys, iss_rw_phys;
  logic [PAYLOAD_W-1:0] iss_payload;
  logic [CNT_W-1:0]     count;

  instr_issue_queue #(
    .DEPTH(DEPTH), .PTAG_W(PTAG_W), .PAYLOAD_W(PAYLOAD_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_rs_phys(alloc_rs_phys), .alloc_rt_phys(alloc_rt_phys), .alloc_rw_phys(alloc_rw_phys),
    .alloc_uses_rs(alloc_uses_rs), .alloc_uses_rt(alloc_uses_rt),
    .alloc_rs_rdy(alloc_rs_rdy), .alloc_rt_rdy(alloc_rt_rdy), .alloc_payload(alloc_payload),
    .wb_valid(wb_valid), .wb_phys(wb_phys),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs_phys(iss_rs_phys), .iss_rt_phys(iss_rt_phys), .iss_rw_phys(iss_rw_phys),
    .iss_payload(iss_payload), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PTAG_W-1:0]    rs, rt, rw;
    bit                   rsr, rtr;
    logic [PAYLOAD_W-1:0] pl;
  } ent_t;

  typedef struct {
    bit                   v, ar, zero;
    logic [CNT_W-1:0]     cnt;
    logic [PTAG_W-1:0]    rs, rt, rw;
    logic [PAYLOAD_W-1:0] pl;
  } exp_t;

  ent_t mq[$];
  exp_t sb[$];
  exp_t me;
  bit   prev_rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [PAYLOAD_W-1:0] act, input logic [PAYLOAD_W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Model evaluates the cycle whose inputs are now applied, queues the
  // expected outputs, then advances to the state after the coming edge.
  task automatic model_cycle();
    exp_t e;
    ent_t n;
    int   sel = -1;
    bit   do_alloc;
    foreach (mq[k]) if (sel < 0 && mq[k].rsr && mq[k].rtr) sel = k;
    e.v    = (sel >= 0) && !flush;
    e.ar   = mq.size() < DEPTH;
    e.cnt  = CNT_W'(mq.size());
    e.zero = prev_rst;
    e.rs = '0; e.rt = '0; e.rw = '0; e.pl = '0;
    if (sel >= 0) begin
      e.rs = mq[sel].rs; e.rt = mq[sel].rt; e.rw = mq[sel].rw; e.pl = mq[sel].pl;
    end
    sb.push_back(e);
    prev_rst = rst;
    if (rst || flush) begin
      mq.delete();
    end else begin
      do_alloc = alloc_valid && (mq.size() < DEPTH);
      if (e.v && iss_ready) mq.delete(sel);
      if (wb_valid) foreach (mq[k]) begin
        if (mq[k].rs == wb_phys) mq[k].rsr = 1'b1;
        if (mq[k].rt == wb_phys) mq[k].rtr = 1'b1;
      end
      if (do_alloc) begin
        n.rs  = alloc_rs_phys; n.rt = alloc_rt_phys; n.rw = alloc_rw_phys; n.pl = alloc_payload;
        n.rsr = !alloc_uses_rs || alloc_rs_rdy || (wb_valid && wb_phys == alloc_rs_phys);
        n.rtr = !alloc_uses_rt || alloc_rt_rdy || (wb_valid && wb_phys == alloc_rt_phys);
        mq.push_back(n);
      end
    end
  endtask

  task automatic set_idle();
    rst = 1'b0; flush = 1'b0; alloc_valid = 1'b0;
    alloc_rs_phys = '0; alloc_rt_phys = '0; alloc_rw_phys = '0;
    alloc_uses_rs = 1'b0; alloc_uses_rt = 1'b0; alloc_rs_rdy = 1'b0; alloc_rt_rdy = 1'b0;
    alloc_payload = '0; wb_valid = 1'b0; wb_phys = '0; iss_ready = 1'b0;
  endtask

  task automatic alloc_in(input logic [PTAG_W-1:0] rs, input logic [PTAG_W-1:0] rt,
                          input logic [PTAG_W-1:0] rw, input bit urs, input bit urt,
                          input bit rsr, input bit rtr);
    alloc_valid = 1'b1;
    alloc_rs_phys = rs; alloc_rt_phys = rt; alloc_rw_phys = rw;
    alloc_uses_rs = urs; alloc_uses_rt = urt; alloc_rs_rdy = rsr; alloc_rt_rdy = rtr;
    alloc_payload = {$urandom, $urandom, $urandom};
  endtask

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
    set_idle();
  endtask

  function automatic logic [PTAG_W-1:0] rtag();
    return PTAG_W'($urandom_range(0, 15));
  endfunction

  // Monitor: one expectation per cycle, compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        me = sb.pop_front();
        chk("count", PAYLOAD_W'(count), PAYLOAD_W'(me.cnt));
        chk("alloc_ready", PAYLOAD_W'(alloc_ready), PAYLOAD_W'(me.ar));
        chk("iss_valid", PAYLOAD_W'(iss_valid), PAYLOAD_W'(me.v));
        if (me.v || me.zero) begin
          chk("iss_rs_phys", PAYLOAD_W'(iss_rs_phys), PAYLOAD_W'(me.rs));
          chk("iss_rt_phys", PAYLOAD_W'(iss_rt_phys), PAYLOAD_W'(me.rt));
          chk("iss_rw_phys", PAYLOAD_W'(iss_rw_phys), PAYLOAD_W'(me.rw));
          chk("iss_payload", iss_payload, me.pl);
        end
      end
    end
  end

  initial begin
    set_idle();
    rst = 1'b1;
    @(posedge clk); #1;
    // Reset state, then single ready instruction with rw=7.
    rst = 1'b1; step();
    step();
    alloc_in(6'd1, 6'd2, 6'd7, 1, 1, 1, 1); iss_ready = 1'b1; step();
    iss_ready = 1'b1; step();
    step();
    // Younger ready B overtakes A; A wakes from tag 5.
    alloc_in(6'd5, 6'd0, 6'd10, 1, 0, 0, 0); step();
    alloc_in(6'd3, 6'd4, 6'd11, 1, 1, 1, 1); iss_ready = 1'b1; step();
    iss_ready = 1'b1; step();
    wb_valid = 1'b1; wb_phys = 6'd5; iss_ready = 1'b1; step();
    iss_ready = 1'b1; step();
    step();
    // Fill to full, then issue and alloc together at full.
    for (int k = 0; k < DEPTH; k++) begin
      alloc_in(rtag(), rtag(), PTAG_W'(k + 32), 1, 1, 1, 1); step();
    end
    step();
    iss_ready = 1'b1; alloc_in(6'd1, 6'd1, 6'd60, 1, 1, 1, 1); step();
    step();
    for (int k = 0; k < DEPTH; k++) begin
      iss_ready = 1'b1; step();
    end
    // Alloc-time bypass of tag 9.
    alloc_in(6'd9, 6'd0, 6'd12, 1, 0, 0, 0); wb_valid = 1'b1; wb_phys = 6'd9; step();
    iss_ready = 1'b1; step();
    step();
    // Flush a 10-entry queue with a competing alloc and issue.
    for (int k = 0; k < 10; k++) begin
      alloc_in(6'd30, 6'd31, PTAG_W'(k), 1, 1, 0, 1); step();
    end
    flush = 1'b1; iss_ready = 1'b1; alloc_in(6'd1, 6'd2, 6'd3, 1, 1, 1, 1); step();
    step();
    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      if ($urandom_range(0, 59) == 0) flush = 1'b1;
      if ($urandom_range(0, 99) < 60)
        alloc_in(rtag(), rtag(), rtag(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wb_valid  = ($urandom_range(0, 99) < 40);
      wb_phys   = rtag();
      iss_ready = ($urandom_range(0, 99) < 60);
      step();
    end
    @(negedge clk); #1;
    chk("scoreboard_drained", PAYLOAD_W'(sb.size()), PAYLOAD_W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
